// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter. It carries the two requester ports, the response
// signals (ack/rdata/gnt) and the single-port RAM pins.
interface ram_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds
  // them until ackN pulses for one cycle. It drops reqN in that ack cycle
  // unless it wants another transaction. Once the port is granted, dropping
  // req does not cancel the transaction.
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata, gnt, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata, gnt, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port (CPU = port 0, DMA = port 1) arbiter in front of a single-port RAM
// with asynchronous read. Define ARB_RR_EN for round-robin arbitration;
// otherwise port 0 has fixed priority.
module ram_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      bus,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              gnt_q;
  logic              cmd_we_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              grant_en;
  logic              win;

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    win      = gnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d  = ACCESS;
          grant_en = 1'b1;
`ifdef ARB_RR_EN
          // On a tie the port that was not granted last time wins.
          if (bus.req0 && bus.req1) win = ~gnt_q;
          else                      win = bus.req1;
`else
          win = ~bus.req0;
`endif
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b1;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        gnt_q       <= win;
        cmd_we_q    <= win ? bus.we1    : bus.we0;
        cmd_addr_q  <= win ? bus.addr1  : bus.addr0;
        cmd_wdata_q <= win ? bus.wdata1 : bus.wdata0;
      end
      if (state_q == ACCESS && !cmd_we_q) rdata_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state_q == ACCESS) begin
      bus.mem_we    = cmd_we_q;
      bus.mem_re    = ~cmd_we_q;
      bus.mem_addr  = cmd_addr_q;
      bus.mem_wdata = cmd_wdata_q;
    end
  end

  assign bus.ack0  = (state_q == RESP) && !gnt_q;
  assign bus.ack1  = (state_q == RESP) &&  gnt_q;
  assign bus.rdata = rdata_q;
  assign bus.gnt   = gnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural async-read RAM.
// Inputs are driven and outputs sampled on the falling edge.
module tb_ram_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic       clk;
  logic       rst;
  logic [1:0] state;

  ram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic [DATA_W-1:0] ram [2**ADDR_W];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = ram[bus.mem_addr];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  logic exp_g;

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) ram[i] = '0;
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    check("rst_state", state, 0);
    check("rst_gnt", bus.gnt, 1);
    check("rst_rdata", bus.rdata, 0);
    check("rst_ack0", bus.ack0, 0);
    check("rst_ack1", bus.ack1, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_re", bus.mem_re, 0);

    // port 0 write 0xDEADBEEF to address 3
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 3; bus.wdata0 = 32'hDEADBEEF;
    tick();
    check("w_state", state, 1);
    check("w_mem_we", bus.mem_we, 1);
    check("w_mem_re", bus.mem_re, 0);
    check("w_mem_addr", bus.mem_addr, 3);
    check("w_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("w_gnt", bus.gnt, 0);
    check("w_ack0_early", bus.ack0, 0);
    tick();
    check("w_ack0", bus.ack0, 1);
    check("w_ack1", bus.ack1, 0);
    check("w_resp_mem_we", bus.mem_we, 0);
    check("w_resp_mem_addr", bus.mem_addr, 0);
    bus.req0 = 0;
    tick();
    check("w_idle", state, 0);
    check("w_ack0_gone", bus.ack0, 0);

    // port 0 read of address 3
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3; bus.wdata0 = '0;
    tick();
    check("r_mem_re", bus.mem_re, 1);
    check("r_mem_we", bus.mem_we, 0);
    check("r_mem_addr", bus.mem_addr, 3);
    tick();
    check("r_ack0", bus.ack0, 1);
    check("r_rdata", bus.rdata, 32'hDEADBEEF);
    bus.req0 = 0;
    tick();

    // port 1 write 0x12345678 to address 31
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 31; bus.wdata1 = 32'h12345678;
    tick();
    check("w1_mem_we", bus.mem_we, 1);
    check("w1_mem_addr", bus.mem_addr, 31);
    check("w1_gnt", bus.gnt, 1);
    tick();
    check("w1_ack1", bus.ack1, 1);
    check("w1_ack0", bus.ack0, 0);
    check("w1_rdata_kept", bus.rdata, 32'hDEADBEEF);
    bus.req1 = 0;
    tick();

    // port 1 read of address 31, req dropped during ACCESS
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 31; bus.wdata1 = '0;
    tick();
    check("r1_mem_re", bus.mem_re, 1);
    check("r1_mem_addr", bus.mem_addr, 31);
    bus.req1 = 0;
    tick();
    check("r1_ack1", bus.ack1, 1);
    check("r1_rdata", bus.rdata, 32'h12345678);
    tick();
    check("r1_idle", state, 0);

    // reset during ACCESS of a port-0 read
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3;
    tick();
    check("ra_access", state, 1);
    rst = 1; bus.req0 = 0;
    tick();
    rst = 0;
    check("ra_state", state, 0);
    check("ra_mem_re", bus.mem_re, 0);
    check("ra_rdata", bus.rdata, 0);
    check("ra_ack0", bus.ack0, 0);
    tick();
    check("ra_ack0_later", bus.ack0, 0);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3;
    tick();
    check("ra2_mem_re", bus.mem_re, 1);
    tick();
    check("ra2_ack0", bus.ack0, 1);
    check("ra2_rdata", bus.rdata, 32'hDEADBEEF);
    bus.req0 = 0;
    tick();

    // contention from reset: both ports reading continuously
    rst = 1;
    tick();
    rst = 0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 3;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 31;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      exp_g = (i % 2 == 1);
`else
      exp_g = 1'b0;
`endif
      tick();
      check($sformatf("c%0d_state", i), state, 1);
      check($sformatf("c%0d_gnt", i), bus.gnt, exp_g);
      tick();
      check($sformatf("c%0d_ack0", i), bus.ack0, !exp_g);
      check($sformatf("c%0d_ack1", i), bus.ack1, exp_g);
      check($sformatf("c%0d_rdata", i), bus.rdata, exp_g ? 32'h12345678 : 32'hDEADBEEF);
      tick();
      check($sformatf("c%0d_gap", i), bus.ack0 | bus.ack1, 0);
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
